mem_responder: RTL
==================

# mem_responder

Memory responder for the multicycle RV32I core: the target end of the core's load/store/fetch memory port. It accepts one request at a time from the core's control path, inserts a programmable number of wait states, and performs word, halfword or byte accesses on an internal word-organised RAM. It returns sign- or zero-extended load data plus a one-cycle completion/error pulse, so the main control FSM can stall in its memory states until the access completes.

## Interface
- ADDR_WIDTH, 10, word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words; valid byte addresses are 0 .. 4*2^ADDR_WIDTH-1
- WAIT_STATES, 2, extra cycles inserted before every access; legal range 0..15

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present; sampled only in IDLE
- req_we  in  1  1 = store, 0 = load/fetch
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
- req_funct3  in  3  RV32I size code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- req_ready  out  1  one-cycle completion pulse
- rsp_rdata  out  32  registered load data; valid when req_ready=1, held until the next completed load
- rsp_err  out  1  qualifies req_ready; 1 = request rejected
- busy  out  1  1 in every state except IDLE

## Operation
- States: IDLE, WAIT, ACCESS, RESP, ERR.
- IDLE with req_valid=1: capture we/addr/wdata/funct3 into request registers and check the request.
  - Error conditions:
    - funct3 in {011, 110, 111}
    - store with funct3 in {100, 101}
    - halfword with addr[0]=1
    - word with addr[1:0]!=0
    - any addr bit [31:ADDR_WIDTH+2] set
  - Error -> ERR. Otherwise -> WAIT with counter=WAIT_STATES-1, or -> ACCESS directly when WAIT_STATES=0.
- WAIT: decrement the counter; at 0 -> ACCESS.
- ACCESS: one cycle at RAM word index addr[ADDR_WIDTH+1:2].
  - Store: write the RAM at the end of the cycle with byte strobes.
    - SB: lane addr[1:0] gets wdata[7:0].
    - SH: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
    - SW: all lanes.
    - Unstrobed lanes are unchanged.
  - Load: rsp_rdata is loaded at the end of the cycle.
    - LB/LBU: selected byte, sign-/zero-extended.
    - LH/LHU: selected halfword, sign-/zero-extended.
    - LW: whole word.
  - Store leaves rsp_rdata unchanged.
  - -> RESP.
- RESP: req_ready=1, rsp_err=0 -> IDLE.
- ERR: req_ready=1, rsp_err=1; no RAM write; rsp_rdata unchanged -> IDLE.
- Requester holds req_valid and the request fields stable until it sees req_ready. Fields are captured in IDLE, so later changes are ignored.
- req_valid high in the cycle after req_ready is treated as a new request.
- The RAM is not reset and has no initial-content requirement beyond simulator default or the test preload.

## Timing
- Reset values, immediately on rst low, independent of clk:
  - state=IDLE, counter=0
  - req_ready=0, rsp_err=0, busy=0, rsp_rdata=0
  - RAM contents untouched
- Request sampled in IDLE in cycle N:
  - Good request: req_ready high in cycle N+WAIT_STATES+2, for exactly one cycle; next request accepted no earlier than sampling in N+WAIT_STATES+3.
  - Error: req_ready and rsp_err high in cycle N+1.
- busy rises in N+1 and falls in the cycle after req_ready.
- req_ready, rsp_err and busy are decoded from registered state only; no combinational path from inputs.
- Reset asserted during WAIT or ACCESS before the ACCESS clock edge: the access is aborted, no RAM write occurs, and no req_ready is issued.
- req_valid=0 in IDLE: stay in IDLE; outputs unchanged except req_ready and rsp_err, which are 0.

## Test plan
- Reset: drive rst=0 mid-WAIT of a SW to 0x10 (WAIT_STATES=2), then release and LW 0x10 -> original word returned, req_ready never pulsed for the aborted store, all outputs 0 while in reset.
- Word path: SW 0xDEADBEEF to 0x20 sampled in cycle 0 -> req_ready in cycle 4, rsp_err=0; then LW 0x20 -> rsp_rdata=0xDEADBEEF with req_ready 4 cycles after sampling.
- Byte/half lanes: after the word above, SB 0x5A to 0x22 and SH 0x1234 to 0x20 -> LW 0x20 returns 0xDE5A1234; LB 0x23 -> 0xFFFFFFDE; LBU 0x23 -> 0x000000DE; LH 0x22 -> 0xFFFFDE5A; LHU 0x22 -> 0x0000DE5A.
- Errors: LW 0x21, SH 0x31, SB with funct3=100, LW 0x00001000 (ADDR_WIDTH=10) -> each gives req_ready+rsp_err in cycle N+1, RAM unchanged, and rsp_rdata keeps its previous value.
- Zero wait states (WAIT_STATES=0): back-to-back SW/LW with req_valid held high -> req_ready every 3rd cycle (N+2, N+5, ...) and correct data.
- Idle stability: req_valid low for 20 cycles -> busy=0, req_ready=0, rsp_rdata unchanged.

Source files
------------

// File: rtl/mem_responder.sv
// Target end of the core's memory port: one request at a time, programmable wait states,
// byte/halfword/word access to an internal word-organised RAM with extended load data.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        req_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StWait, StAccess, StResp, StErr} state_e;

  localparam int unsigned Words    = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [2:0]            funct3_q;
  logic [31:0]           rdata_q;
  logic                  req_bad;

  logic [31:0]           mem [Words];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           rd_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           load_val;
  logic [3:0]            wstrb;
  logic [31:0]           wlanes;

  // Request check works on the live inputs so the IDLE decision needs no extra cycle.
  always_comb begin
    req_bad = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: req_bad = 1'b1;
      3'b100:                 req_bad = req_we;
      3'b101:                 req_bad = req_we | req_addr[0];
      3'b001:                 req_bad = req_addr[0];
      3'b010:                 req_bad = |req_addr[1:0];
      default:                req_bad = 1'b0;
    endcase
    if ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0) req_bad = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_bad) begin
            state_d = StErr;
          end else if (WAIT_STATES == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StAccess;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      StErr:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StResp) || (state_q == StErr);
    rsp_err   = (state_q == StErr);
    busy      = (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= 3'd0;
    end else if (state_q == StIdle && req_valid) begin
      we_q     <= req_we;
      addr_q   <= req_addr[ADDR_WIDTH+1:0];
      wdata_q  <= req_wdata;
      funct3_q <= req_funct3;
    end
  end

  assign word_idx = addr_q[ADDR_WIDTH+1:2];
  assign rd_word  = mem[word_idx];

  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3_q[1:0])
      2'b00:   load_val = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   load_val = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
      default: load_val = rd_word;
    endcase
  end

  // Store data is replicated across lanes so the strobe alone picks the target bytes.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        wlanes = {4{wdata_q[7:0]}};
        wstrb  = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        wlanes = {2{wdata_q[15:0]}};
        wstrb  = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wlanes = wdata_q;
        wstrb  = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == StAccess && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'd0;
    end else if (state_q == StAccess && !we_q) begin
      rdata_q <= load_val;
    end
  end

  assign rsp_rdata = rdata_q;

endmodule
